// File: rtl/jk_ff_bank_pkg.sv
//==============================================================================
// Module      : jk_ff_bank_pkg
// Description : Shared mode encodings and types for the jk_ff_bank slice.
//               MODE_JK / MODE_D / MODE_T / MODE_SR select the per-bit
//               next-state function of the flip-flop bank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package jk_ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK = 2'b00;
    localparam mode_t MODE_D  = 2'b01;
    localparam mode_t MODE_T  = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

endpackage : jk_ff_bank_pkg

`default_nettype wire

// File: rtl/jk_ff_next.sv
//==============================================================================
// Module      : jk_ff_next
// Description : Combinational single-bit next-state cell for jk_ff_bank.
//   Ports:
//     q       in   current flip-flop state
//     j       in   J / D / T / S input
//     k       in   K / R input (unused in D and T modes)
//     mode    in   next-state function select
//     q_nx    out  next state when the bank is enabled
//     illegal out  S=R=1 seen in SR mode
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jk_ff_next
    import jk_ff_bank_pkg::*;
(
    input  logic  q,
    input  logic  j,
    input  logic  k,
    input  mode_t mode,
    output logic  q_nx,
    output logic  illegal
);

    always_comb begin
        q_nx    = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b10:   q_nx = 1'b1;
                    2'b01:   q_nx = 1'b0;
                    2'b11:   q_nx = ~q;
                    default: q_nx = q;
                endcase
            end
            MODE_D:  q_nx = j;
            MODE_T:  q_nx = q ^ j;
            MODE_SR: begin
                case ({j, k})
                    2'b10:   q_nx = 1'b1;
                    2'b01:   q_nx = 1'b0;
                    // S=R=1: the bit holds and the condition is flagged.
                    2'b11:   illegal = 1'b1;
                    default: q_nx = q;
                endcase
            end
            default: q_nx = q;
        endcase
    end

endmodule : jk_ff_next

`default_nettype wire

// File: rtl/jk_ff_bank.sv
//==============================================================================
// Module      : jk_ff_bank
// Description : Bank of WIDTH flip-flops with runtime-selectable JK / D / T /
//               SR next-state function, clock enable, synchronous parallel
//               load, registered change detection and sticky SR error flag.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   synchronous active-low reset
//     en       in   enables mode-based update
//     mode     in   next-state function select
//     j, k     in   per-bit flip-flop inputs
//     load     in   parallel load strobe (overrides en)
//     load_val in   value written on load
//     err_clr  in   clears sr_err (a coincident set wins)
//     q, qn    out  state and its complement
//     changed  out  previous edge altered q
//     sr_err   out  sticky illegal-SR flag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic             sr_err
);

    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_illegal;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             changed_q;
    logic             changed_d;
    logic             sr_err_q;
    logic             sr_err_d;
    logic             w_err_set;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_ff_next u_next (
            .q       (q_q[gi]),
            .j       (j[gi]),
            .k       (k[gi]),
            .mode    (mode),
            .q_nx    (w_q_nx[gi]),
            .illegal (w_illegal[gi])
        );
    end

    // Load beats enable; with neither, the bank holds.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = w_q_nx;
        end
    end

    assign changed_d = (q_d != q_q);

    // The cell flags illegal only in SR mode; a load or a disabled cycle
    // never raises the error.
    assign w_err_set = en && !load && (|w_illegal);
    assign sr_err_d  = w_err_set || (sr_err_q && !err_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
            sr_err_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            sr_err_q  <= sr_err_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign changed = changed_q;
    assign sr_err  = sr_err_q;

endmodule : jk_ff_bank

`default_nettype wire

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised bank of WIDTH edge-triggered flip-flops with per-bit J/K inputs and a runtime-selectable next-state mode: JK, D, T or SR. It replaces single-bit JK flip-flop instances wherever a multi-bit state or control register is needed. It adds a clock enable, a synchronous parallel load, registered change detection and a sticky illegal-SR error flag.

## Interface
Parameters:
- WIDTH, 8, number of flip-flops in the bank (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- en  in  1  clock enable for mode-based update
- mode  in  2  next-state function (see Operation)
- j  in  WIDTH  per-bit J / D / T / S input, depending on mode
- k  in  WIDTH  per-bit K / R input; ignored in D and T modes
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value written on load
- err_clr  in  1  clears sr_err
- q  out  WIDTH  flip-flop state
- qn  out  WIDTH  ~q, combinational from q
- changed  out  1  registered; 1 when the previous edge altered any bit of q
- sr_err  out  1  sticky; set when any bit sees S=R=1 in SR mode

## Operation
- Mode encoding: 2'b00 JK, 2'b01 D, 2'b10 T, 2'b11 SR.
- Per-bit next state q_nx[i] when en=1:
  - JK: 00 hold, 10 set, 01 reset, 11 toggle.
  - D: q_nx = j[i].
  - T: j[i]=1 toggles the bit; j[i]=0 holds it.
  - SR: 10 set, 01 reset, 00 hold. 11 is illegal: the bit holds.
- Priority at each rising edge, highest first: reset, then load, then en, then hold.
  - !rst_n: q=RESET_VAL, changed=0, sr_err=0.
  - load=1: q=load_val regardless of en and mode. The illegal-SR check is suppressed this cycle.
  - en=1: q=q_nx.
  - en=0: q holds and no error is detected.
- changed <= (q_next_registered != q_current) on every non-reset edge, including load edges.
- sr_err is set when en=1, load=0, mode=SR and (j & k) != 0. It is cleared by err_clr=1.
  - If set and clear occur on the same edge, set wins.
  - Otherwise sr_err holds.
- mode may change on any cycle. It is sampled only at the edge; no internal mode state is held.

## Timing
- All outputs except qn are registered. q, changed and sr_err update one clk edge after their inputs are sampled. qn follows q combinationally.
- Reset is synchronous: asserting rst_n=0 takes effect at the next rising edge, not asynchronously.
- While rst_n=0, all other inputs are ignored.
- Reset asserted mid-operation, including on a load or illegal-SR cycle, takes priority: q=RESET_VAL, sr_err=0, changed=0.
- Reset value of every output: q=RESET_VAL, qn=~RESET_VAL, changed=0, sr_err=0.
- No multicycle paths. The next-state logic is one level of per-bit muxing.

## Structure
- Shared package jk_ff_bank_pkg holds:
  - localparams MODE_JK=2'b00, MODE_D=2'b01, MODE_T=2'b10, MODE_SR=2'b11;
  - mode_t, a 2-bit typedef.
- Sub-module jk_ff_next: a combinational single-bit next-state cell.
  - Inputs: q, j, k, mode. Outputs: q_nx, illegal.
  - Instantiated WIDTH times in a generate loop.
- Top-level jk_ff_bank contains the q register, the load/en priority mux, the changed compare register, and the sr_err OR-reduce and sticky logic.

## Test plan
- Reset: drive rst_n=0 for 2 edges with j=k=8'hFF, load=1 → q=8'h00, qn=8'hFF, changed=0, sr_err=0. Also confirm q does not change before the first edge with rst_n low.
- JK mode, en=1, from q=8'h00:
  - j=8'hF0, k=8'h0F → q=8'hF0, changed=1.
  - Then j=k=8'hFF → q=8'h0F.
  - Then j=k=8'h00 → q=8'h0F, changed=0.
- D and T modes:
  - D with j=8'hA5 → q=8'hA5.
  - Then T with j=8'hFF → q=8'h5A.
  - Then en=0, j=8'hFF → q stays 8'h5A, changed=0.
- SR illegal, from q=8'h5A:
  - mode=SR, j=8'h81, k=8'h01 → q=8'hDA (bit 7 set, bit 0 held), sr_err=1.
  - Next cycle: err_clr=1 with the same j/k → sr_err stays 1 (set wins).
  - Then err_clr=1 with k=8'h00 → sr_err=0.
- Load priority: load=1, load_val=8'h3C, en=1, mode=SR, j=k=8'hFF → q=8'h3C, sr_err unchanged, changed=1.
- Reset mid-operation: rst_n=0 on an edge with load=1, load_val=8'hFF and a pending illegal SR → q=RESET_VAL, sr_err=0. Repeat with RESET_VAL=8'h81, WIDTH=1 and WIDTH=16 builds.
